// File: rtl/input_event_pkg.sv
// input_event_pkg: frame constants, frame FSM states and the frame byte selector.
package input_event_pkg;
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int FRAME_BYTES = 5;
    localparam int LINE_W = 12;
    localparam int TS_W = 16;
    localparam int ENTRY_W = TS_W + LINE_W;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} frame_state_e;

    // Entry layout is {ts, lines}; byte 3 carries the upper four line bits zero-extended.
    function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] e, input logic [2:0] idx);
        return idx == 3'd0 ? FRAME_HDR :
               idx == 3'd1 ? e[ENTRY_W-1:ENTRY_W-8] :
               idx == 3'd2 ? e[ENTRY_W-9:LINE_W] :
               idx == 3'd3 ? {4'h0, e[11:8]} : e[7:0];
    endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser, LSB first, idle high, one-cycle done at the end of the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [8:0]    sh_q;
    logic          active_q;
    logic          tx_q;
    logic          done_q;

    // bit_q: 0 = start, 1..8 = data, 9 = stop; sh_q holds the bits still to go out, stop bit on top.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '1;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (start) begin
                    active_q <= 1'b1;
                    tx_q     <= 1'b0;
                    sh_q     <= {1'b1, data};
                    cnt_q    <= '0;
                    bit_q    <= '0;
                end
            end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    tx_q  <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[8:1]};
                    bit_q <= bit_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
endmodule

// File: rtl/input_event_uart.sv
// input_event_uart: timestamps changes on In_Lines, queues them and streams 5-byte frames over UART.
module input_event_uart
    import input_event_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TICK_DIV     = 100000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [LINE_W-1:0] In_Lines,
    input  logic              TimeStamp,
    output logic              UART_TX,
    output logic              Busy,
    output logic              Overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [LINE_W-1:0]  prev_lines_q;
    logic               ts_lvl_q;
    logic [TS_W-1:0]    ts_q;
    logic [PW-1:0]      pre_q;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]        wr_q;
    logic [AW:0]        rd_q;
    logic               ovf_q;
    frame_state_e       state_q;
    logic [2:0]         idx_q;
    logic [ENTRY_W-1:0] frame_q;
    logic               start_q;
    logic [7:0]         byte_q;
    logic               ts_clr;
    logic               tick;
    logic [TS_W-1:0]    ts_now;
    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    logic               wr_ok;
    logic               done;

    // A clear coincident with an event must already show up in the captured entry.
    assign ts_clr = TimeStamp & ~ts_lvl_q;
    assign tick   = pre_q == PW'(TICK_DIV - 1);
    assign ts_now = ts_clr ? '0 : ts_q;
    assign push   = In_Lines != prev_lines_q;
    assign pop    = state_q == LOAD;
    assign empty  = wr_q == rd_q;
    assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign wr_ok  = push && (!full || pop);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_lines_q <= In_Lines;
            ts_lvl_q     <= TimeStamp;
            ts_q         <= '0;
            pre_q        <= '0;
        end else begin
            prev_lines_q <= In_Lines;
            ts_lvl_q     <= TimeStamp;
            pre_q        <= (ts_clr || tick) ? '0 : pre_q + 1'b1;
            ts_q         <= ts_clr ? '0 : tick ? ts_q + 1'b1 : ts_q;
        end
    end

    // When full, a simultaneous pop frees the slot being written, so the push still lands.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_q[AW-1:0]] <= {ts_now, In_Lines};
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !wr_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            start_q <= 1'b0;
            byte_q  <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (!empty) state_q <= LOAD;
                LOAD: begin
                    frame_q <= mem_q[rd_q[AW-1:0]];
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    start_q <= 1'b1;
                    byte_q  <= frame_byte(frame_q, idx_q);
                    state_q <= WAIT;
                end
                WAIT: if (done) begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= (idx_q + 3'd1 < 3'(FRAME_BYTES)) ? SEND : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start_q),
        .data  (byte_q),
        .tx    (UART_TX),
        .done  (done)
    );

    assign Busy     = !empty || state_q != IDLE;
    assign Overflow = ovf_q;
endmodule

// File: tb/tb_input_event_uart.sv
// tb_input_event_uart: random event bursts checked against a timestamp/frame model and a bit-level UART monitor.
module tb_input_event_uart;
    localparam int CPB = 4;
    localparam int TD  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_rst = 1'b1;
    logic        ts_in = 1'b0;
    logic        w_ts_in = 1'b0;
    logic [11:0] in_lines = '0;
    logic [11:0] w_lines = '0;
    logic        uart_tx, busy, overflow;
    logic        w_tx, w_busy, w_ovf;
    logic        use_wrap = 1'b0;
    logic        mon_tx, mon_rst, mon_busy;
    longint      edge_n = 0;
    longint      clr_edge = 0;
    longint      w_clr = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  rx_q [$];
    longint      rx_edge_q [$];
    logic [27:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    assign mon_tx   = use_wrap ? w_tx : uart_tx;
    assign mon_rst  = use_wrap ? w_rst : rst;
    assign mon_busy = use_wrap ? w_busy : busy;

    input_event_uart #(.CLKS_PER_BIT(CPB), .TICK_DIV(TD), .FIFO_DEPTH(8)) u_dut (
        .Clk(clk), .Reset(rst), .In_Lines(in_lines), .TimeStamp(ts_in),
        .UART_TX(uart_tx), .Busy(busy), .Overflow(overflow)
    );

    input_event_uart #(.CLKS_PER_BIT(CPB), .TICK_DIV(1), .FIFO_DEPTH(8)) u_wrap (
        .Clk(clk), .Reset(w_rst), .In_Lines(w_lines), .TimeStamp(w_ts_in),
        .UART_TX(w_tx), .Busy(w_busy), .Overflow(w_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Timestamp seen by an event sampled at edge e: ticks elapsed since the last clear.
    function automatic logic [15:0] exp_ts(input longint e);
        return (e == clr_edge) ? 16'h0 : 16'((e - 1 - clr_edge) / TD);
    endfunction

    task automatic send_ev(input logic [11:0] v);
        if (v == in_lines) v = v ^ 12'h001;
        in_lines = v;
        exp_q.push_back({exp_ts(edge_n + 1), v});
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        repeat (3) @(negedge clk);
        for (int i = 0; i < budget && mon_busy; i++) @(negedge clk);
        check("idle_timeout", {31'h0, mon_busy}, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_frames(input string tag);
        logic [27:0] f;
        logic [39:0] fr;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            f  = exp_q.pop_front();
            fr = {8'hA5, f[27:12], 4'h0, f[11:0]};
            for (int b = 0; b < 5; b++) begin
                if (rx_q.size() > 0) got = {24'h0, rx_q.pop_front()};
                else got = 32'hFFFF_FFFF;
                check(tag, got, {24'h0, fr[39-8*b -: 8]});
            end
        end
        check({tag, "_extra"}, rx_q.size(), 0);
        rx_q.delete();
        rx_edge_q.delete();
    endtask

    // Samples every clock so that start, data and stop bits must each last exactly CPB clocks.
    initial begin
        logic [9:0] bits;
        bit         ok, ab;
        longint     st;
        forever begin
            @(posedge clk); #2;
            if (mon_tx === 1'b0 && mon_rst === 1'b0) begin
                st = edge_n; ok = 1'b1; ab = 1'b0; bits = '0;
                for (int i = 0; i < 10 * CPB; i++) begin
                    if (i > 0) begin
                        @(posedge clk); #2;
                    end
                    if (mon_rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (i % CPB == 0) bits[i/CPB] = mon_tx;
                    else if (mon_tx !== bits[i/CPB]) ok = 1'b0;
                end
                if (!ab) begin
                    check("bit_timing", {31'h0, ok}, 1);
                    check("stop_bit", {31'h0, bits[9]}, 1);
                    rx_q.push_back(bits[8:1]);
                    rx_edge_q.push_back(st);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          any_low, any_busy;
        int          n;
        longint      d;
        logic [7:0]  s2_exp [5];
        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, uart_tx}, 1);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_ovf", {31'h0, overflow}, 0);
        rst = 1'b0; w_rst = 1'b0;
        clr_edge = edge_n; w_clr = edge_n;

        any_low = 0; any_busy = 0;
        repeat (200) begin
            @(negedge clk);
            any_low  |= !uart_tx;
            any_busy |= busy;
        end
        check("s1_tx_low", {31'h0, any_low}, 0);
        check("s1_busy", {31'h0, any_busy}, 0);
        check("s1_frames", rx_q.size(), 0);

        ts_in = 1'b1; clr_edge = edge_n + 1;
        @(negedge clk);
        ts_in = 1'b0;
        repeat (34) @(negedge clk);
        send_ev(12'h801);
        wait_idle(1000);
        s2_exp = '{8'hA5, 8'h00, 8'h03, 8'h08, 8'h01};
        check("s2_size", rx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check("s2_byte", rx_q.size() > i ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF, {24'h0, s2_exp[i]});
        for (int i = 1; i < 5; i++) begin
            d = rx_edge_q.size() > i ? rx_edge_q[i] - rx_edge_q[i-1] : 0;
            check("s2_gap", {31'h0, d >= 40 && d <= 43}, 1);
        end
        compare_frames("s2_frame");

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                send_ev(12'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle(n * 300 + 100);
            compare_frames("rand_frame");
        end
        check("rand_no_ovf", {31'h0, overflow}, 0);

        for (int k = 0; k < 10; k++) send_ev(12'($urandom));
        wait_idle(4000);
        n = rx_q.size();
        check("s3_frames", {31'h0, n == 40 || n == 45}, 1);
        check("s3_ovf", {31'h0, overflow}, 1);
        while (exp_q.size() > n / 5) void'(exp_q.pop_back());
        compare_frames("s3_frame");

        send_ev(12'h5A3);
        for (int i = 0; i < 2000 && rx_q.size() < 2; i++) @(negedge clk);
        check("s5_two_bytes", rx_q.size(), 2);
        check("s5_hdr", rx_q.size() > 0 ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF, 32'hA5);
        check("s5_ovf_sticky", {31'h0, overflow}, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s5_tx", {31'h0, uart_tx}, 1);
        check("s5_busy", {31'h0, busy}, 0);
        check("s5_ovf", {31'h0, overflow}, 0);
        rst = 1'b0; clr_edge = edge_n;
        any_low = 0; any_busy = 0;
        repeat (200) begin
            @(negedge clk);
            any_low  |= !uart_tx;
            any_busy |= busy;
        end
        check("s5_tx_low", {31'h0, any_low}, 0);
        check("s5_busy_after", {31'h0, any_busy}, 0);
        check("s5_residual", rx_q.size(), 2);
        rx_q.delete(); rx_edge_q.delete(); exp_q.delete();

        repeat (57) @(negedge clk);
        ts_in = 1'b1; clr_edge = edge_n + 1;
        send_ev(12'h0F0);
        ts_in = 1'b0;
        wait_idle(1000);
        check("s6_ts_hi", rx_q.size() > 1 ? {24'h0, rx_q[1]} : 32'hFFFF_FFFF, 0);
        check("s6_ts_lo", rx_q.size() > 2 ? {24'h0, rx_q[2]} : 32'hFFFF_FFFF, 0);
        compare_frames("s6_frame");

        use_wrap = 1'b1;
        while (edge_n < w_clr + 65535) @(negedge clk);
        w_lines = 12'h001;
        @(negedge clk);
        w_lines = 12'h002;
        @(negedge clk);
        exp_q.push_back({16'hFFFF, 12'h001});
        exp_q.push_back({16'h0000, 12'h002});
        wait_idle(1000);
        compare_frames("wrap_frame");
        check("wrap_ovf", {31'h0, w_ovf}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
